vs_demux_dispatcher_1x4: RTL and testbench

- Registered valid/ready dispatch stage that sits directly upstream of the 1x4 combinational demultiplexer.
- Accepts one data word per handshake and picks a destination channel 0..3, either round-robin or explicit.
- Holds the word in a single output register and drives it as select + data, with a one-hot per-channel valid.
- Keeps a per-channel delivered-word counter for debug and throughput checks.

---
 rtl/vs_demux_dispatcher_1x4_if.sv | 31 +++
 rtl/vs_demux_dispatcher_1x4.sv | 93 +++++++++
 tb/tb_vs_demux_dispatcher_1x4.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/vs_demux_dispatcher_1x4_if.sv
// Handshake/bus bundle around the 1x4 dispatch stage.
//   in_valid/in_ready/in_data/in_mode/in_dest : upstream word and destination choice
//   out_select/out_data/out_valid/out_ready   : held word presented to the demux
//   sent_cnt                                  : packed per-channel delivered counters
// master : upstream producer + downstream consumers (drives in_*, out_ready)
// slave  : the dispatcher
interface vs_demux_dispatcher_1x4_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic               in_mode;
  logic [1:0]         in_dest;
  logic [1:0]         out_select;
  logic [WIDTH-1:0]   out_data;
  logic [3:0]         out_valid;
  logic [3:0]         out_ready;
  logic [4*CNT_W-1:0] sent_cnt;

  modport master (
    output in_valid, in_data, in_mode, in_dest, out_ready,
    input  in_ready, out_select, out_data, out_valid, sent_cnt
  );

  modport slave (
    input  in_valid, in_data, in_mode, in_dest, out_ready,
    output in_ready, out_select, out_data, out_valid, sent_cnt
  );
endinterface

// File: rtl/vs_demux_dispatcher_1x4.sv
// Registered valid/ready dispatch stage feeding a 1x4 combinational demux.
// Holds one word, presents it as select + data with a one-hot valid, and
// counts delivered words per channel.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : slave side of vs_demux_dispatcher_1x4_if (see interface header)
module vs_demux_dispatcher_1x4 #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  vs_demux_dispatcher_1x4_if.slave bus
);

  localparam int unsigned NCH = 4;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [1:0]         sel_q;
  logic [WIDTH-1:0]   data_q;
  logic [NCH-1:0]     valid_q;
  logic [1:0]         rr_q;
  logic [CNT_W-1:0]   cnt_q [NCH];

  logic               drain_c;
  logic               in_ready_c;
  logic               accept_c;
  logic [1:0]         dest_c;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // Next-state: accept always leaves us FULL; only a drain without a
  // simultaneous accept empties the stage.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (accept_c) state_d = FULL;
      FULL:    if (drain_c && !accept_c) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // Handshake decode; in_ready allows pass-through when the held word drains
  always_comb begin
    drain_c    = 1'b0;
    in_ready_c = 1'b0;
    accept_c   = 1'b0;
    dest_c     = rr_q;
    drain_c    = (state_q == FULL) && bus.out_ready[sel_q];
    in_ready_c = rst_n && ((state_q == EMPTY) || drain_c);
    accept_c   = bus.in_valid && in_ready_c;
    if (bus.in_mode) dest_c = bus.in_dest;
  end

  // Output register, round-robin pointer and delivered counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_q   <= '0;
      data_q  <= '0;
      valid_q <= '0;
      rr_q    <= '0;
      for (int k = 0; k < NCH; k++) cnt_q[k] <= '0;
    end else begin
      // Counter tracks the channel being drained, before any reload of sel_q
      if (drain_c) cnt_q[sel_q] <= cnt_q[sel_q] + CNT_W'(1);
      if (accept_c) begin
        data_q  <= bus.in_data;
        sel_q   <= dest_c;
        valid_q <= 4'b0001 << dest_c;
        if (!bus.in_mode) rr_q <= rr_q + 2'd1;
      end else if (drain_c) begin
        data_q  <= '0;
        valid_q <= '0;
      end
    end
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.out_select = sel_q;
  assign bus.out_data   = data_q;
  assign bus.out_valid  = valid_q;

  for (genvar k = 0; k < NCH; k++) begin : g_cnt
    assign bus.sent_cnt[k*CNT_W +: CNT_W] = cnt_q[k];
  end

endmodule

// File: tb/tb_vs_demux_dispatcher_1x4.sv
// Directed bench for vs_demux_dispatcher_1x4 (CNT_W=2 so counter wrap is reachable).
module tb_vs_demux_dispatcher_1x4;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  vs_demux_dispatcher_1x4_if #(.WIDTH(8), .CNT_W(2)) bus ();

  vs_demux_dispatcher_1x4 #(.WIDTH(8), .CNT_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] rr_data [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
  logic [1:0] rr_sel  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [1:0] wrap_exp[5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one word for a single edge (caller ensures in_ready), then check load
  task automatic send(input logic [7:0] d, input logic m, input logic [1:0] dst,
                      input logic [1:0] exp_sel, input string tag);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_mode  = m;
    bus.in_dest  = dst;
    tick();
    bus.in_valid = 1'b0;
    chk({tag, "_sel"},   32'(bus.out_select), 32'(exp_sel));
    chk({tag, "_data"},  32'(bus.out_data),   32'(d));
    chk({tag, "_valid"}, 32'(bus.out_valid),  32'(4'b0001 << exp_sel));
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_mode   = 1'b0;
    bus.in_dest   = '0;
    bus.out_ready = 4'b0000;

    // Reset held for two edges
    tick();
    tick();
    chk("rst_valid",  32'(bus.out_valid),  32'h0);
    chk("rst_data",   32'(bus.out_data),   32'h0);
    chk("rst_sel",    32'(bus.out_select), 32'h0);
    chk("rst_ready",  32'(bus.in_ready),   32'h0);
    chk("rst_cnt",    32'(bus.sent_cnt),   32'h0);

    // Round-robin, back-to-back with all consumers ready
    rst_n = 1'b1;
    bus.out_ready = 4'b1111;
    bus.in_valid  = 1'b1;
    bus.in_mode   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.in_data = rr_data[i];
      #1;
      chk("rr_in_ready", 32'(bus.in_ready), 32'h1);
      tick();
      chk("rr_sel",   32'(bus.out_select), 32'(rr_sel[i]));
      chk("rr_data",  32'(bus.out_data),   32'(rr_data[i]));
      chk("rr_valid", 32'(bus.out_valid),  32'(4'b0001 << rr_sel[i]));
    end
    bus.in_valid = 1'b0;
    tick();
    chk("rr_empty_valid", 32'(bus.out_valid), 32'h0);
    chk("rr_empty_data",  32'(bus.out_data),  32'h0);
    // counters {c3,c2,c1,c0} = {1,1,1,2}
    chk("rr_cnt", 32'(bus.sent_cnt), 32'h56);

    // Backpressure on channel 2 with a second word pending
    bus.out_ready = 4'b1011;
    send(8'hA5, 1'b1, 2'd2, 2'd2, "bp_load");
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h5A;
    bus.in_mode  = 1'b1;
    bus.in_dest  = 2'd1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_valid", 32'(bus.out_valid), 32'h4);
      chk("bp_data",  32'(bus.out_data),  32'hA5);
      chk("bp_ready", 32'(bus.in_ready),  32'h0);
      if (i < 2) tick();
    end
    bus.out_ready = 4'b1111;
    #1;
    chk("bp_pass_ready", 32'(bus.in_ready), 32'h1);
    tick();
    bus.in_valid = 1'b0;
    chk("bp_pass_valid", 32'(bus.out_valid), 32'h2);
    chk("bp_pass_data",  32'(bus.out_data),  32'h5A);
    // c2 1->2 on drain; {1,2,1,2}
    chk("bp_pass_cnt",   32'(bus.sent_cnt),  32'h66);
    tick();
    // c1 1->2; {1,2,2,2}
    chk("bp_drain_cnt",   32'(bus.sent_cnt),  32'h6A);
    chk("bp_drain_valid", 32'(bus.out_valid), 32'h0);

    // Explicit words do not move the pointer (pointer is at 1 here)
    send(8'h01, 1'b0, 2'd0, 2'd1, "ex_rr1");
    send(8'h02, 1'b1, 2'd3, 2'd3, "ex_d3a");
    send(8'h03, 1'b1, 2'd3, 2'd3, "ex_d3b");
    send(8'h04, 1'b0, 2'd0, 2'd2, "ex_rr2");
    tick();
    // {3,3,3,2}
    chk("ex_cnt", 32'(bus.sent_cnt), 32'hFE);

    // Non-selected readies are ignored while holding on channel 1
    bus.out_ready = 4'b1101;
    send(8'h77, 1'b1, 2'd1, 2'd1, "ns_load");
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("ns_valid", 32'(bus.out_valid), 32'h2);
      chk("ns_data",  32'(bus.out_data),  32'h77);
      chk("ns_cnt",   32'(bus.sent_cnt),  32'hFE);
    end
    bus.out_ready = 4'b1111;
    tick();
    // c1 wraps 3->0; {3,3,0,2}
    chk("ns_wrap_cnt", 32'(bus.sent_cnt), 32'hF2);

    // Fresh reset, then five words to channel 0 with a drain cycle each
    rst_n = 1'b0;
    #1;
    chk("rst2_ready", 32'(bus.in_ready), 32'h0);
    tick();
    rst_n = 1'b1;
    chk("rst2_cnt", 32'(bus.sent_cnt), 32'h0);
    for (int i = 0; i < 5; i++) begin
      send(8'(8'hC0 + i), 1'b1, 2'd0, 2'd0, "wr_load");
      tick();
      chk("wr_cnt0", 32'(bus.sent_cnt[1:0]), 32'(wrap_exp[i]));
    end
    chk("wr_cnt_all", 32'(bus.sent_cnt), 32'h01);

    // Reset while holding a word on channel 2
    bus.out_ready = 4'b1011;
    send(8'h99, 1'b1, 2'd2, 2'd2, "mr_load");
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mr_valid", 32'(bus.out_valid), 32'h0);
    chk("mr_data",  32'(bus.out_data),  32'h0);
    chk("mr_cnt",   32'(bus.sent_cnt),  32'h0);
    bus.out_ready = 4'b1111;
    send(8'hC3, 1'b0, 2'd0, 2'd0, "mr_rr");
    tick();
    chk("mr_final_cnt", 32'(bus.sent_cnt), 32'h01);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
